// File: rtl/vga_timing_pkg.sv
// Shared raster constants and parameter helpers for the VGA timing generator.
// Defaults describe 640x480 at 60 Hz with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    localparam int unsigned POS_WIDTH = 10;
    localparam int unsigned MAX_TOTAL = 1024;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return visible + front + sync + back;
    endfunction

    function automatic int unsigned sync_start(input int unsigned visible,
                                               input int unsigned front);
        return visible + front;
    endfunction

    function automatic int unsigned sync_end(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync);
        return visible + front + sync;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap detect and a registered sync pin level.
// The sync flop is loaded from the next position so it stays aligned with o_pos.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL           = 800,
    parameter int unsigned SYNC_START      = 656,
    parameter int unsigned SYNC_END        = 752,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_advance,
    output logic [POS_WIDTH-1:0] o_pos,
    output logic [POS_WIDTH-1:0] o_pos_next_c,
    output logic                 o_wrap_c,
    output logic                 o_sync
);

    localparam logic [POS_WIDTH-1:0] LAST_POS  = POS_WIDTH'(TOTAL - 1);
    localparam logic [POS_WIDTH-1:0] START_POS = POS_WIDTH'(SYNC_START);
    localparam logic [POS_WIDTH-1:0] END_POS   = POS_WIDTH'(SYNC_END);
    localparam logic                 SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic [POS_WIDTH-1:0] pos_d, pos_q;
    logic                 sync_d, sync_q;
    logic                 wrap_c;

    always_comb begin
        pos_d  = pos_q;
        wrap_c = i_advance && (pos_q == LAST_POS);
        if (i_advance) begin
            pos_d = wrap_c ? '0 : pos_q + POS_WIDTH'(1);
        end
        sync_d = ((pos_d >= START_POS) && (pos_d < END_POS)) ? ~SYNC_IDLE : SYNC_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pos_q  <= '0;
            sync_q <= SYNC_IDLE;
        end else begin
            pos_q  <= pos_d;
            sync_q <= sync_d;
        end
    end

    assign o_pos        = pos_q;
    assign o_pos_next_c = pos_d;
    assign o_wrap_c     = wrap_c;
    assign o_sync       = sync_q;

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing source: pixel position, visible flag, syncs and frame strobe, all registered.
// Optional o_line_strobe is built when VGA_TIMING_LINE_STROBE_EN is defined.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE       = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT         = DEF_H_FRONT,
    parameter int unsigned H_SYNC          = DEF_H_SYNC,
    parameter int unsigned H_BACK          = DEF_H_BACK,
    parameter int unsigned V_VISIBLE       = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT         = DEF_V_FRONT,
    parameter int unsigned V_SYNC          = DEF_V_SYNC,
    parameter int unsigned V_BACK          = DEF_V_BACK,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    output logic [POS_WIDTH-1:0] o_hpos,
    output logic [POS_WIDTH-1:0] o_vpos,
    output logic                 o_visible,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_frame_strobe
`ifdef VGA_TIMING_LINE_STROBE_EN
    ,
    output logic                 o_line_strobe
`endif
);

    localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [POS_WIDTH-1:0] H_LAST  = POS_WIDTH'(H_TOTAL - 1);
    localparam logic [POS_WIDTH-1:0] V_LAST  = POS_WIDTH'(V_TOTAL - 1);
    localparam logic [POS_WIDTH-1:0] H_VIS_P = POS_WIDTH'(H_VISIBLE);
    localparam logic [POS_WIDTH-1:0] V_VIS_P = POS_WIDTH'(V_VISIBLE);

    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_check
        $error("vga_timing_generator: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_check
        $error("vga_timing_generator: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
    end

    logic [POS_WIDTH-1:0] h_next_c, v_next_c;
    logic                 h_wrap_c, v_wrap_unused_c;
    logic                 run_d, run_q;
    logic                 visible_d, visible_q;
    logic                 frame_strobe_d, frame_strobe_q;

    // Horizontal axis holds at 0 for the first post-reset edge so (0,0) is presented first.
    vga_axis_counter #(
        .TOTAL           (H_TOTAL),
        .SYNC_START      (sync_start(H_VISIBLE, H_FRONT)),
        .SYNC_END        (sync_end(H_VISIBLE, H_FRONT, H_SYNC)),
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_h_axis (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_advance    (run_q),
        .o_pos        (o_hpos),
        .o_pos_next_c (h_next_c),
        .o_wrap_c     (h_wrap_c),
        .o_sync       (o_hsync)
    );

    vga_axis_counter #(
        .TOTAL           (V_TOTAL),
        .SYNC_START      (sync_start(V_VISIBLE, V_FRONT)),
        .SYNC_END        (sync_end(V_VISIBLE, V_FRONT, V_SYNC)),
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_v_axis (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_advance    (h_wrap_c),
        .o_pos        (o_vpos),
        .o_pos_next_c (v_next_c),
        .o_wrap_c     (v_wrap_unused_c),
        .o_sync       (o_vsync)
    );

    always_comb begin
        run_d          = 1'b1;
        visible_d      = (h_next_c < H_VIS_P) && (v_next_c < V_VIS_P);
        frame_strobe_d = (h_next_c == H_LAST) && (v_next_c == V_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            run_q          <= 1'b0;
            visible_q      <= 1'b0;
            frame_strobe_q <= 1'b0;
        end else begin
            run_q          <= run_d;
            visible_q      <= visible_d;
            frame_strobe_q <= frame_strobe_d;
        end
    end

    assign o_visible      = visible_q;
    assign o_frame_strobe = frame_strobe_q;

`ifdef VGA_TIMING_LINE_STROBE_EN
    logic line_strobe_d, line_strobe_q;

    always_comb begin
        line_strobe_d = (h_next_c == H_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            line_strobe_q <= 1'b0;
        end else begin
            line_strobe_q <= line_strobe_d;
        end
    end

    assign o_line_strobe = line_strobe_q;
`endif

endmodule
